// File: rtl/clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clock_mode_ctrl
//  Purpose  : Mode / sequencing controller for a digital alarm clock. Drives
//             the counter-bank enables, handles run / time-set / alarm-set
//             modes, detects the alarm match and times the ringing output.
//  Revision : 1.0  initial release
// ============================================================================
module clock_mode_ctrl #(
    parameter int RING_SECS = 60,
    parameter int HR_W      = 5,
    parameter int MIN_W     = 6
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic             tick,
    input  logic             btn_mode,
    input  logic             btn_up,
    input  logic             btn_stop,
    input  logic             alarm_on,
    input  logic [MIN_W-1:0] sec,
    input  logic [MIN_W-1:0] min,
    input  logic [HR_W-1:0]  hr,
    input  logic [MIN_W-1:0] al_min,
    input  logic [HR_W-1:0]  al_hr,
    output logic             sec_en,
    output logic             min_en,
    output logic             hr_en,
    output logic             al_min_en,
    output logic             al_hr_en,
    output logic             sec_clr,
    output logic [2:0]       mode,
    output logic             ringing
);

    localparam int               RC_W         = $clog2(RING_SECS + 1);
    localparam logic [RC_W-1:0]  c_ring_load  = RC_W'(RING_SECS);
    localparam logic [RC_W-1:0]  c_ring_last  = RC_W'(1);
    localparam logic [MIN_W-1:0] c_max_59     = MIN_W'(59);

    typedef enum logic [2:0] {
        ST_RUN        = 3'd0,
        ST_SET_HR     = 3'd1,
        ST_SET_MIN    = 3'd2,
        ST_SET_AL_HR  = 3'd3,
        ST_SET_AL_MIN = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_ringing;
    logic            r_sec_clr;
    logic [RC_W-1:0] r_ring_cnt;
    logic            r_btn_mode_q;
    logic            r_btn_up_q;
    logic            r_btn_stop_q;

    logic w_mode_edge;
    logic w_up_edge;
    logic w_stop_edge;
    logic w_up_press;
    logic w_stop;
    logic w_match;
    logic w_sec59;
    logic w_min59;

    // History registers reset high, so a button held through reset is not an edge
    assign w_mode_edge = btn_mode & ~r_btn_mode_q;
    assign w_up_edge   = btn_up   & ~r_btn_up_q;
    assign w_stop_edge = btn_stop & ~r_btn_stop_q;

    // A mode press in the same cycle swallows the up press
    assign w_up_press  = w_up_edge & ~w_mode_edge;

    assign w_sec59 = (sec == c_max_59);
    assign w_min59 = (min == c_max_59);

    // Any of these ends an active ring; the tick term is the countdown expiring
    assign w_stop = w_stop_edge | w_mode_edge | ~alarm_on
                  | (tick & (r_ring_cnt == c_ring_last));

    // New match is suppressed whenever a stop condition is present
    assign w_match = (r_state == ST_RUN) & alarm_on & tick
                   & (hr == al_hr) & (min == al_min) & (sec == '0)
                   & ~w_stop_edge & ~w_mode_edge;

    assign mode    = r_state;
    assign ringing = r_ringing;
    assign sec_clr = r_sec_clr;

    // Counter enables: carry cascade in RUN, single-shot field increments in SET modes
    always_comb begin
        sec_en    = 1'b0;
        min_en    = 1'b0;
        hr_en     = 1'b0;
        al_min_en = 1'b0;
        al_hr_en  = 1'b0;
        if (rst) begin
            case (r_state)
                ST_RUN: begin
                    sec_en = tick;
                    min_en = tick & w_sec59;
                    hr_en  = tick & w_sec59 & w_min59;
                end
                ST_SET_HR:     hr_en     = w_up_press;
                ST_SET_MIN:    min_en    = w_up_press;
                ST_SET_AL_HR:  al_hr_en  = w_up_press;
                ST_SET_AL_MIN: al_min_en = w_up_press;
                default: ;
            endcase
        end
    end

    // Mode FSM, alarm ring timer, seconds-clear pulse and button history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_RUN;
            r_ringing    <= 1'b0;
            r_ring_cnt   <= '0;
            r_sec_clr    <= 1'b0;
            r_btn_mode_q <= 1'b1;
            r_btn_up_q   <= 1'b1;
            r_btn_stop_q <= 1'b1;
        end else begin
            r_btn_mode_q <= btn_mode;
            r_btn_up_q   <= btn_up;
            r_btn_stop_q <= btn_stop;
            r_sec_clr    <= 1'b0;

            if (r_ringing) begin
                if (w_stop) begin
                    r_ringing  <= 1'b0;
                    r_ring_cnt <= '0;
                end else if (tick) begin
                    r_ring_cnt <= r_ring_cnt - 1'b1;
                end
            end else if (w_match) begin
                r_ringing  <= 1'b1;
                r_ring_cnt <= c_ring_load;
            end

            // While ringing a mode press only silences the alarm
            case (r_state)
                ST_RUN:
                    if (w_mode_edge && !r_ringing) r_state <= ST_SET_HR;
                ST_SET_HR:
                    if (w_mode_edge && !r_ringing) r_state <= ST_SET_MIN;
                ST_SET_MIN:
                    if (w_mode_edge && !r_ringing) begin
                        r_state   <= ST_SET_AL_HR;
                        r_sec_clr <= 1'b1;
                    end
                ST_SET_AL_HR:
                    if (w_mode_edge && !r_ringing) r_state <= ST_SET_AL_MIN;
                ST_SET_AL_MIN:
                    if (w_mode_edge && !r_ringing) r_state <= ST_RUN;
                default:
                    r_state <= ST_RUN;
            endcase
        end
    end

endmodule
`default_nettype wire
